// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl
// Sequential multi-operand accumulator. Operands arrive one per cycle over a
// valid/ready handshake and are folded into a redundant (sum, carry) pair by a
// single 3:2 carry-save compressor. After the last operand of a group, one
// carry-propagate add resolves the total. The result is then held on a
// valid/ready output until the consumer takes it. Groups never overlap.
// ACC_W must be at least DATA_W+1. All arithmetic wraps silently mod 2^ACC_W.
module csa_accum_ctrl #(
  parameter int DATA_W = 11,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Sum bit of a 3:2 compressor, applied bitwise across the word.
  function automatic logic [ACC_W-1:0] csa_sum(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] c
  );
    return a ^ b ^ c;
  endfunction

  // Carry word of a 3:2 compressor: majority moved up one weight. The bit
  // leaving the top is worth 2^ACC_W and is dropped, which keeps the
  // redundant pair exact modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] csa_carry(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] c
  );
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  // Operand counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   sum_r, sum_s;
  logic [ACC_W-1:0]   carry_r, carry_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [ACC_W-1:0]   out_sum_r, out_sum_s;
  logic [CNT_W-1:0]   out_count_r, out_count_s;
  logic               out_valid_r, out_valid_s;

  logic               take_s;
  logic               accept_s;
  logic [ACC_W-1:0]   x_s;
  logic [ACC_W-1:0]   base_sum_s;
  logic [ACC_W-1:0]   base_carry_s;
  logic [CNT_W-1:0]   base_cnt_s;

  // Input side is open only while collecting a group, not during an abort,
  // and never while reset is held.
  assign take_s   = (state_r == IDLE) || (state_r == ACCUM);
  assign in_ready = rst_n & ~clear & take_s;
  assign accept_s = in_valid & in_ready;

  // Operand zero-extended to the accumulator width.
  assign x_s = {{(ACC_W-DATA_W){1'b0}}, in_data};

  // A fresh group always compresses against an all-zero redundant total,
  // independent of whatever the registers hold in IDLE.
  assign base_sum_s   = (state_r == IDLE) ? {ACC_W{1'b0}} : sum_r;
  assign base_carry_s = (state_r == IDLE) ? {ACC_W{1'b0}} : carry_r;
  assign base_cnt_s   = (state_r == IDLE) ? {CNT_W{1'b0}} : cnt_r;

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_count = out_count_r;

  // Next-state and datapath update: compress on accept, resolve once, hold the
  // result until the consumer takes it.
  always_comb begin
    state_s     = state_r;
    sum_s       = sum_r;
    carry_s     = carry_r;
    cnt_s       = cnt_r;
    out_sum_s   = out_sum_r;
    out_count_s = out_count_r;
    out_valid_s = out_valid_r;

    case (state_r)
      IDLE, ACCUM: begin
        if (clear) begin
          // Abort: drop the partial group; in_ready is already low.
          sum_s   = {ACC_W{1'b0}};
          carry_s = {ACC_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = IDLE;
        end else if (accept_s) begin
          sum_s   = csa_sum(base_sum_s, base_carry_s, x_s);
          carry_s = csa_carry(base_sum_s, base_carry_s, x_s);
          cnt_s   = sat_inc(base_cnt_s);
          state_s = in_last ? RESOLVE : ACCUM;
        end else begin
          // No operand this cycle: everything holds.
          state_s = state_r;
        end
      end

      RESOLVE: begin
        // Single carry-propagate add; the top carry-out wraps away.
        out_sum_s   = sum_r + carry_r;
        out_count_s = cnt_r;
        out_valid_s = 1'b1;
        state_s     = OUTPUT;
      end

      OUTPUT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          sum_s       = {ACC_W{1'b0}};
          carry_s     = {ACC_W{1'b0}};
          cnt_s       = {CNT_W{1'b0}};
          state_s     = IDLE;
        end else begin
          // Consumer stalled: result stays on the port unchanged.
          state_s = state_r;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle state.
        sum_s       = {ACC_W{1'b0}};
        carry_s     = {ACC_W{1'b0}};
        cnt_s       = {CNT_W{1'b0}};
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State, redundant accumulator and registered result, async-cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sum_r       <= {ACC_W{1'b0}};
      carry_r     <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_sum_r   <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sum_r       <= sum_s;
      carry_r     <= carry_s;
      cnt_r       <= cnt_s;
      out_sum_r   <= out_sum_s;
      out_count_r <= out_count_s;
      out_valid_r <= out_valid_s;
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: a table of directed groups, hand
// sequences for abort / reset / backpressure, and randomized groups checked
// against a plain-arithmetic model of the group total.
module tb_csa_accum_ctrl;

  localparam int DATA_W = 11;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;

  int total;
  int bad;

  typedef struct {
    logic [DATA_W-1:0] val;
    int                n;
    int                hold;
    logic [ACC_W-1:0]  exp_sum;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  vec_t tbl[5];

  csa_accum_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Present one operand and wait (bounded) for it to be accepted. Returns
  // at the falling edge after the accepting rising edge.
  task automatic send_op(input logic [DATA_W-1:0] d, input logic l);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int w = 0; w < 20 && !ok; w++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Called right after the last operand's send_op: checks the 2-cycle
  // latency, holds out_ready low for 'hold' cycles checking stability, then
  // hands the result off and checks that input side reopens.
  task automatic get_result(input int hold, input logic [ACC_W-1:0] es,
                            input logic [CNT_W-1:0] ec, input bit use_clear);
    int lat;
    lat = 1;
    if (use_clear) clear = 1'b1;
    if (hold == 0 && !use_clear) out_ready = 1'b1;
    #1;
    chk("resolve_no_valid", out_valid, 0);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 2);
    chk("out_valid", out_valid, 1);
    chk("out_sum", out_sum, es);
    chk("out_count", out_count, ec);
    chk("in_ready_output", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, es);
      chk("stall_count", out_count, ec);
      chk("stall_in_ready", in_ready, 0);
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    longint acc;
    int     n;
    int     hold;
    logic [DATA_W-1:0] d;
    logic [ACC_W-1:0]  es;
    logic [CNT_W-1:0]  ec;

    total = 0;
    bad   = 0;

    tbl[0] = '{11'd2047, 3,  0, 16'd6141,  8'd3};
    tbl[1] = '{11'd5,    1,  0, 16'd5,     8'd1};
    tbl[2] = '{11'd2047, 32, 1, 16'd65504, 8'd32};
    tbl[3] = '{11'd2047, 33, 2, 16'd2015,  8'd33};
    tbl[4] = '{11'd0,    4,  0, 16'd0,     8'd4};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Directed table.
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) send_op(tbl[i].val, k == tbl[i].n - 1);
      get_result(tbl[i].hold, tbl[i].exp_sum, tbl[i].exp_cnt, 1'b0);
    end

    // Backpressure: {100,200,300} stalled 5 cycles.
    send_op(11'd100, 1'b0);
    send_op(11'd200, 1'b0);
    send_op(11'd300, 1'b1);
    get_result(5, 16'd600, 8'd3, 1'b0);

    // clear while the result is pending is ignored.
    send_op(11'd10, 1'b0);
    send_op(11'd20, 1'b1);
    get_result(3, 16'd30, 8'd2, 1'b1);

    // Abort: 7, 9, then clear with operand 11 presented.
    send_op(11'd7, 1'b0);
    send_op(11'd9, 1'b0);
    in_valid = 1'b1;
    in_data  = 11'd11;
    in_last  = 1'b1;
    clear    = 1'b1;
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("clear_no_valid", out_valid, 0);
    send_op(11'd4, 1'b1);
    get_result(0, 16'd4, 8'd1, 1'b0);

    // Reset during ACCUM.
    send_op(11'd1000, 1'b0);
    send_op(11'd1000, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_accum_in_ready", in_ready, 0);
    chk("rst_accum_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during OUTPUT drops out_valid asynchronously.
    send_op(11'd50, 1'b1);
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
    end
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sum", out_sum, 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_output_valid", out_valid, 0);
    chk("rst_output_sum", out_sum, 0);
    chk("rst_output_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_op(11'd3, 1'b0);
    send_op(11'd4, 1'b1);
    get_result(0, 16'd7, 8'd2, 1'b0);

    // Randomized groups against an arithmetic model; the last one is long
    // enough to saturate the operand count.
    for (int g = 0; g < 31; g++) begin
      n    = (g == 30) ? 260 : int'($urandom_range(1, 40));
      hold = int'($urandom_range(0, 3));
      acc  = 0;
      for (int k = 0; k < n; k++) begin
        d   = DATA_W'($urandom_range(0, 2047));
        acc = acc + longint'(d);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        send_op(d, k == n - 1);
      end
      es = ACC_W'(acc % 65536);
      ec = (n > 255) ? 8'd255 : CNT_W'(n);
      get_result(hold, es, ec, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
